mem_line_ctrl: RTL
==================

Name: mem_line_ctrl

Overview:
Downstream neighbour of the cache's lower-level (lc_*) port. It accepts whole-line fill and write-back requests and serialises each line into word-wide beats on a simple pipelined word memory port. For fills, it reassembles returned beats into a full line and hands that line back to the cache over a valid/ready response channel. One transaction is in flight at a time.

Parameters:
- W, 64, address width in bits.
- LINE_BITS, 512, cache line width.
- WORD_BITS, 64, memory port data width.
- BEATS, LINE_BITS/WORD_BITS (8), localparam: beats per line.
- OFF_BITS, $clog2(LINE_BITS/8) (6), localparam: line byte-offset width.

Ports:
- clk_in  in  1  clock; all logic on posedge.
- rst_in  in  1  reset; asynchronous, active-high.
- req_valid_in  in  1  cache request valid.
- req_ready_out  out  1  controller can accept a request.
- req_addr_in  in  W  request byte address.
- req_we_in  in  1  1 = write-back, 0 = fill.
- req_line_in  in  LINE_BITS  write-back line data.
- resp_valid_out  out  1  fill line valid.
- resp_ready_in  in  1  cache accepts the fill.
- resp_addr_out  out  W  line-aligned fill address.
- resp_line_out  out  LINE_BITS  fill line data.
- mem_en_out  out  1  beat command valid.
- mem_we_out  out  1  beat is a write.
- mem_addr_out  out  W  beat byte address.
- mem_wdata_out  out  WORD_BITS  beat write data.
- mem_ready_in  in  1  memory accepts the beat this cycle.
- mem_rvalid_in  in  1  read data beat returned.
- mem_rdata_in  in  WORD_BITS  read data; returns in issue order, latency ≥1.

Behaviour:
- Reset (async): state IDLE. All outputs are 0 except req_ready_out, which is 1. Beat and return counters are 0. An in-flight transaction is abandoned; its beats are not replayed.
- The request handshake fires on req_valid_in & req_ready_out. req_ready_out is 1 only in IDLE.
- On handshake, the controller latches:
  - base = req_addr_in with the low OFF_BITS cleared.
  - start offset = 0.
  - req_line_in.
- FSM states: IDLE, WR_BEATS, RD_ISSUE, RD_WAIT, RESP.
  - IDLE → WR_BEATS on handshake with we = 1.
  - IDLE → RD_ISSUE on handshake with we = 0.
- WR_BEATS:
  - mem_en_out = 1, mem_we_out = 1.
  - mem_addr_out = base + idx*8.
  - mem_wdata_out = line word idx, where word 0 is bits [63:0].
  - idx advances only on mem_ready_in.
  - After beat BEATS-1 is accepted → IDLE. Write-backs produce no response.
- RD_ISSUE:
  - mem_en_out = 1, mem_we_out = 0.
  - Same address sequencing as WR_BEATS.
  - After the last beat is accepted → RD_WAIT, or → RESP if the final beat has already returned.
- Read returns (RD_ISSUE or RD_WAIT):
  - Each mem_rvalid_in writes mem_rdata_in into the line-buffer slot of the matching issued beat.
  - The return counter increments on each beat.
  - When the BEATS-th return arrives → RESP on the next edge.
- Stray mem_rvalid_in in IDLE, WR_BEATS or RESP is ignored.
- RESP:
  - resp_valid_out = 1; resp_addr_out = base; resp_line_out = buffer.
  - All three are held stable until resp_ready_in.
  - On resp_ready_in → IDLE, so req_ready_out is 1 the following cycle.
- Latency, with mem_ready_in = 1 and read latency L:
  - Request accepted at cycle 0; beats issued at cycles 1..8; last return at cycle 8+L.
  - resp_valid_out rises at cycle 9+L.
  - A write-back returns to IDLE at cycle 9.
- Counters are $clog2(BEATS)+1 bits. Beat index arithmetic wraps modulo BEATS.
- mem_en_out is deasserted in every state other than WR_BEATS and RD_ISSUE.

Optional Feature:
- Macro CRIT_WORD_FIRST_EN.
- Defined:
  - Fills latch start offset = req_addr_in[OFF_BITS-1:3].
  - Issue order is start, start+1, …, wrapping modulo BEATS.
  - Returns are still stored by true word slot, so resp_line_out is always in natural order.
- Undefined: start offset is fixed at 0.
- Write-backs always start at word 0 in both builds.

Decomposition:
- Package mem_ctrl_pkg holds:
  - typedef mem_state_t (FSM enum).
  - constants BEAT_BYTES = 8 and the default LINE_BITS / WORD_BITS.
  - a function beat_addr(base, idx).
- One natural sub-module, line_beat_buf:
  - Holds the LINE_BITS buffer with word-indexed write (fill) and word-indexed read (write-back mux).
  - Contains no FSM.

Test Plan:
- Write-back, addr 0x1000, word k = 0x1111_0000 + k, mem_ready_in = 1:
  - mem writes to 0x1000, 0x1008, …, 0x1038 with matching data on cycles 1..8.
  - req_ready_out high again at cycle 9.
  - No resp_valid_out.
- Fill, addr 0x2010, memory model returns addr ^ 0xA5A5 with L = 3:
  - resp_valid_out at cycle 12.
  - resp_addr_out = 0x2000.
  - Word k = (0x2000 + 8k) ^ 0xA5A5.
- Fill with resp_ready_in low for 5 cycles:
  - resp_* held stable.
  - req_ready_out stays 0.
  - Single handshake on release, then IDLE.
- Fill with mem_ready_in low during beats 3–4:
  - mem_addr_out holds 0x2018 while stalled.
  - Exactly 8 beats issued; line still correct.
- With CRIT_WORD_FIRST_EN, fill addr 0x1028:
  - Issue order 0x1028, 0x1030, 0x1038, 0x1000, …, 0x1020.
  - resp_line_out is in natural word order.
- rst_in pulsed mid-RD_WAIT, with 2 returns still outstanding:
  - Outputs return to reset values immediately.
  - Late mem_rvalid_in is ignored.
  - A following fill of 0x3000 completes correctly.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the line-to-word memory controller.
// Consumed by mem_line_ctrl (CRIT_WORD_FIRST_EN selects critical-word-first fills there).
package mem_ctrl_pkg;

  localparam int BEAT_BYTES    = 8;
  localparam int DEF_LINE_BITS = 512;
  localparam int DEF_WORD_BITS = 64;
  localparam int ADDR_BITS     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_BEATS,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP
  } mem_state_t;

  // Byte address of word slot idx within the line starting at base.
  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ADDR_BITS-1:0] base,
                                                     input logic [7:0]           idx);
    return base + ADDR_BITS'(idx) * ADDR_BITS'(BEAT_BYTES);
  endfunction

endpackage

// File: rtl/line_beat_buf.sv
// Line-wide staging buffer: whole-line load for write-backs, word-slot writes for fill
// returns, and a word-slot read mux feeding the write beats.
module line_beat_buf
  import mem_ctrl_pkg::*;
#(
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int IDX_W     = $clog2(LINE_BITS / WORD_BITS)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 load_en,
  input  logic [LINE_BITS-1:0] load_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic [WORD_BITS-1:0] rd_data,
  output logic [LINE_BITS-1:0] line
);

  localparam int BEATS = LINE_BITS / WORD_BITS;

  logic [BEATS-1:0][WORD_BITS-1:0] line_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      line_q <= '0;
    end else if (load_en) begin
      line_q <= load_line;
    end else if (wr_en) begin
      line_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = line_q[rd_idx];
  assign line    = line_q;

endmodule

// File: rtl/mem_line_ctrl.sv
// Serialises whole-line fills/write-backs into word beats on a pipelined memory port.
// Define CRIT_WORD_FIRST_EN to issue fill beats starting at the requested word.
module mem_line_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int W         = 64,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [W-1:0]         req_addr_in,
  input  logic                 req_we_in,
  input  logic [LINE_BITS-1:0] req_line_in,
  output logic                 resp_valid_out,
  input  logic                 resp_ready_in,
  output logic [W-1:0]         resp_addr_out,
  output logic [LINE_BITS-1:0] resp_line_out,
  output logic                 mem_en_out,
  output logic                 mem_we_out,
  output logic [W-1:0]         mem_addr_out,
  output logic [WORD_BITS-1:0] mem_wdata_out,
  input  logic                 mem_ready_in,
  input  logic                 mem_rvalid_in,
  input  logic [WORD_BITS-1:0] mem_rdata_in
);

  localparam int BEATS    = LINE_BITS / WORD_BITS;
  localparam int OFF_BITS = $clog2(LINE_BITS / 8);
  localparam int WOFF     = $clog2(BEAT_BYTES);
  localparam int IDX_W    = $clog2(BEATS);
  localparam int CNT_W    = IDX_W + 1;

  mem_state_t state_q, state_d;

  logic [W-1:0]         base_q;
  logic [IDX_W-1:0]     start_q;
  logic [CNT_W-1:0]     idx_q;
  logic [CNT_W-1:0]     ret_q;
  logic [W-1:0]         req_base;
  logic [IDX_W-1:0]     req_start;
  logic [IDX_W-1:0]     issue_slot;
  logic [IDX_W-1:0]     ret_slot;
  logic [WORD_BITS-1:0] buf_rd_data;
  logic [LINE_BITS-1:0] buf_line;
  logic                 req_fire;
  logic                 issue_fire;
  logic                 ret_fire;
  logic                 last_beat;
  logic                 ret_last;
  logic                 ret_done;

  // Handshakes: a transfer happens on a cycle where both valid and ready are high;
  // valid-side payload is held stable until that cycle; ready may depend only on state.
  assign req_fire   = req_valid_in && (state_q == ST_IDLE);
  assign issue_fire = mem_ready_in && ((state_q == ST_WR_BEATS) || (state_q == ST_RD_ISSUE));
  assign ret_fire   = mem_rvalid_in && ((state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT));
  assign last_beat  = (idx_q == CNT_W'(BEATS - 1));
  assign ret_last   = ret_fire && (ret_q == CNT_W'(BEATS - 1));
  assign ret_done   = (ret_q == CNT_W'(BEATS));

  assign req_base = req_addr_in & ~W'(LINE_BITS / 8 - 1);

`ifdef CRIT_WORD_FIRST_EN
  assign req_start = req_we_in ? '0 : req_addr_in[OFF_BITS-1:WOFF];
`else
  assign req_start = '0;
`endif

  // Returns arrive in issue order, so the n-th return belongs to slot start+n.
  assign issue_slot = start_q + idx_q[IDX_W-1:0];
  assign ret_slot   = start_q + ret_q[IDX_W-1:0];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      start_q <= '0;
      idx_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_fire) begin
        base_q  <= req_base;
        start_q <= req_start;
        idx_q   <= '0;
        ret_q   <= '0;
      end else begin
        if (issue_fire) idx_q <= idx_q + CNT_W'(1);
        if (ret_fire)   ret_q <= ret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    req_ready_out  = 1'b0;
    mem_en_out     = 1'b0;
    mem_we_out     = 1'b0;
    resp_valid_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) state_d = req_we_in ? ST_WR_BEATS : ST_RD_ISSUE;
      end
      ST_WR_BEATS: begin
        mem_en_out = 1'b1;
        mem_we_out = 1'b1;
        if (mem_ready_in && last_beat) state_d = ST_IDLE;
      end
      ST_RD_ISSUE: begin
        mem_en_out = 1'b1;
        if (mem_ready_in && last_beat) state_d = (ret_last || ret_done) ? ST_RESP : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (ret_last) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr_out  = mem_en_out ? W'(beat_addr(ADDR_BITS'(base_q), 8'(issue_slot))) : '0;
  assign mem_wdata_out = mem_we_out ? buf_rd_data : '0;
  assign resp_addr_out = resp_valid_out ? base_q : '0;
  assign resp_line_out = resp_valid_out ? buf_line : '0;

  line_beat_buf #(
    .LINE_BITS (LINE_BITS),
    .WORD_BITS (WORD_BITS),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .load_en   (req_fire),
    .load_line (req_line_in),
    .wr_en     (ret_fire),
    .wr_idx    (ret_slot),
    .wr_data   (mem_rdata_in),
    .rd_idx    (issue_slot),
    .rd_data   (buf_rd_data),
    .line      (buf_line)
  );

endmodule
